// File: rtl/mux41_serializer_if.sv
// Handshake and mux-drive bundle between the word source, the serializer and the 4:1 mux.
interface mux41_serializer_if;
  logic [3:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] mux_d;
  logic [1:0] mux_s;
  logic       busy;
  logic       bit_strobe;
  logic       first_bit;
  logic       last_bit;

  modport master (
    output in_data, in_valid,
    input  in_ready, mux_d, mux_s, busy, bit_strobe, first_bit, last_bit
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, mux_d, mux_s, busy, bit_strobe, first_bit, last_bit
  );
endinterface

// File: rtl/mux41_serializer.sv
// Holds a 4-bit word on the mux data inputs and walks the mux select through all
// four positions, DIV clocks per bit slot, with strobes marking the sample point.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | no word held for serializing; ready for a new word, select at START
// S_SHIFT | word on mux_d, select stepping one slot per DIV clocks
module mux41_serializer #(
  parameter int DIV       = 1,
  parameter bit MSB_FIRST = 1'b0
) (
  input logic          clk,
  input logic          rst_n,
  mux41_serializer_if.slave bus
);

  localparam int          CW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [1:0]  SEL_START = MSB_FIRST ? 2'b11 : 2'b00;
  localparam logic [1:0]  SEL_END   = MSB_FIRST ? 2'b00 : 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b01,
    S_SHIFT = 2'b10
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    mux_d_q, mux_d_d;
  logic [1:0]    mux_s_q, mux_s_d;
  logic [CW-1:0] div_cnt_q, div_cnt_d;

  logic in_ready, busy, bit_strobe, first_bit, last_bit;
  logic accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mux_d_q   <= 4'b0000;
      mux_s_q   <= SEL_START;
      div_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      mux_d_q   <= mux_d_d;
      mux_s_q   <= mux_s_d;
      div_cnt_q <= div_cnt_d;
    end
  end

  // Everything here decodes registered state, so the consumer sees glitch-free timing.
  always_comb begin
    in_ready   = 1'b0;
    busy       = 1'b0;
    bit_strobe = 1'b0;
    first_bit  = 1'b0;
    last_bit   = 1'b0;
    case (state_q)
      S_IDLE: in_ready = 1'b1;
      S_SHIFT: begin
        busy       = 1'b1;
        bit_strobe = (div_cnt_q == CNT_LAST);
        first_bit  = (mux_s_q == SEL_START);
        last_bit   = (mux_s_q == SEL_END);
        in_ready   = bit_strobe && last_bit;
      end
      default: ;
    endcase
  end

  assign accept = bus.in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    mux_d_d   = mux_d_q;
    mux_s_d   = mux_s_q;
    div_cnt_d = div_cnt_q;
    case (state_q)
      S_IDLE: begin
        mux_s_d   = SEL_START;
        div_cnt_d = '0;
        if (accept) begin
          mux_d_d = bus.in_data;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (bit_strobe) begin
          div_cnt_d = '0;
          if (last_bit) begin
            // A word waiting at the END strobe reloads with no idle gap.
            mux_s_d = SEL_START;
            if (accept) mux_d_d = bus.in_data;
            else        state_d = S_IDLE;
          end else begin
            mux_s_d = MSB_FIRST ? (mux_s_q - 2'd1) : (mux_s_q + 2'd1);
          end
        end else begin
          div_cnt_d = div_cnt_q + CW'(1);
        end
      end
      default: begin
        state_d   = S_IDLE;
        mux_s_d   = SEL_START;
        div_cnt_d = '0;
      end
    endcase
  end

  assign bus.in_ready   = in_ready;
  assign bus.busy       = busy;
  assign bus.bit_strobe = bit_strobe;
  assign bus.first_bit  = first_bit;
  assign bus.last_bit   = last_bit;
  assign bus.mux_d      = mux_d_q;
  assign bus.mux_s      = mux_s_q;

endmodule

// File: tb/tb_mux41_serializer.sv
// Bench for mux41_serializer: four instances with different DIV/MSB_FIRST, a bit-level
// scoreboard per instance fed at each handshake and drained at every bit_strobe.
module tb_mux41_serializer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mux41_serializer_if if1 ();
  mux41_serializer_if if3 ();
  mux41_serializer_if if2 ();
  mux41_serializer_if if4 ();

  mux41_serializer #(.DIV(1), .MSB_FIRST(1'b0)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  mux41_serializer #(.DIV(3), .MSB_FIRST(1'b1)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));
  mux41_serializer #(.DIV(2), .MSB_FIRST(1'b0)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
  mux41_serializer #(.DIV(4), .MSB_FIRST(1'b0)) u4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));

  int n_cmp = 0;
  int n_err = 0;
  bit exp_q [4][$];
  int slot_cnt [4];

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard drain: each strobe must present the next expected serial bit.
  task automatic mon(int k, bit msb, logic [3:0] d, logic [1:0] s, logic stb,
                     logic fb, logic lb);
    logic [1:0] exp_s;
    logic       y;
    if (!rst_n) begin
      exp_q[k].delete();
      slot_cnt[k] = 0;
      return;
    end
    if (stb !== 1'b1) return;
    exp_s = msb ? 2'(3 - slot_cnt[k]) : 2'(slot_cnt[k]);
    chk($sformatf("mon_sel%0d", k), 32'(s), 32'(exp_s));
    chk($sformatf("mon_first%0d", k), 32'(fb), 32'(slot_cnt[k] == 0));
    chk($sformatf("mon_last%0d", k), 32'(lb), 32'(slot_cnt[k] == 3));
    y = d[s];
    if (exp_q[k].size() == 0) chk($sformatf("sb_extra%0d", k), 32'd1, 32'd0);
    else chk($sformatf("sb_bit%0d", k), 32'(y), 32'(exp_q[k].pop_front()));
    slot_cnt[k] = (slot_cnt[k] + 1) % 4;
  endtask

  always @(negedge clk) mon(0, 1'b0, if1.mux_d, if1.mux_s, if1.bit_strobe, if1.first_bit, if1.last_bit);
  always @(negedge clk) mon(1, 1'b1, if3.mux_d, if3.mux_s, if3.bit_strobe, if3.first_bit, if3.last_bit);
  always @(negedge clk) mon(2, 1'b0, if2.mux_d, if2.mux_s, if2.bit_strobe, if2.first_bit, if2.last_bit);
  always @(negedge clk) mon(3, 1'b0, if4.mux_d, if4.mux_s, if4.bit_strobe, if4.first_bit, if4.last_bit);

  task automatic push_word(int k, bit msb, logic [3:0] w);
    for (int sl = 0; sl < 4; sl++) exp_q[k].push_back(w[msb ? 3 - sl : sl]);
  endtask

  task automatic chk_idle(virtual mux41_serializer_if vif, string tag, logic [3:0] d, logic [1:0] s);
    chk({tag, "_d"},     32'(vif.mux_d), 32'(d));
    chk({tag, "_s"},     32'(vif.mux_s), 32'(s));
    chk({tag, "_rdy"},   32'(vif.in_ready), 32'd1);
    chk({tag, "_busy"},  32'(vif.busy), 32'd0);
    chk({tag, "_stb"},   32'(vif.bit_strobe), 32'd0);
    chk({tag, "_first"}, 32'(vif.first_bit), 32'd0);
    chk({tag, "_last"},  32'(vif.last_bit), 32'd0);
  endtask

  // Handshake from IDLE; returns just after the accepting edge with in_valid dropped or held.
  task automatic start_word(virtual mux41_serializer_if vif, int k, bit msb,
                            logic [3:0] w, bit hold, logic [3:0] next_data);
    @(posedge clk); #1;
    vif.in_valid = 1'b1;
    vif.in_data  = w;
    @(negedge clk);
    chk($sformatf("hs_ready%0d", k), 32'(vif.in_ready), 32'd1);
    @(posedge clk);
    push_word(k, msb, w);
    #1;
    vif.in_valid = hold;
    vif.in_data  = next_data;
  endtask

  task automatic run_word(virtual mux41_serializer_if vif, int k, int div, bit msb, logic [3:0] w);
    logic [3:0] last_d;
    start_word(vif, k, msb, w, 1'b0, 4'h0);
    for (int c = 0; c < 4 * div; c++) begin
      @(negedge clk);
      chk($sformatf("rw_busy%0d_c%0d", k, c), 32'(vif.busy), 32'd1);
      chk($sformatf("rw_stb%0d_c%0d", k, c), 32'(vif.bit_strobe), 32'(c % div == div - 1));
      chk($sformatf("rw_sel%0d_c%0d", k, c), 32'(vif.mux_s),
          32'(msb ? 3 - c / div : c / div));
      chk($sformatf("rw_d%0d_c%0d", k, c), 32'(vif.mux_d), 32'(w));
    end
    last_d = w;
    @(negedge clk);
    chk_idle(vif, $sformatf("rw_end%0d", k), last_d, msb ? 2'b11 : 2'b00);
  endtask

  // DIV=2 two-word sequence on if2: in_valid is either held (back-to-back) or raised
  // mid-word with data changing while in_ready is low (backpressure).
  task automatic two_words(string tag, logic [3:0] w1, bit hold, logic [3:0] w_early, logic [3:0] w2);
    start_word(if2, 2, 1'b0, w1, hold, w_early);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      chk($sformatf("%s_busy_c%0d", tag, c), 32'(if2.busy), 32'd1);
      chk($sformatf("%s_rdy_c%0d", tag, c), 32'(if2.in_ready), 32'(c % 8 == 7));
      chk($sformatf("%s_stb_c%0d", tag, c), 32'(if2.bit_strobe), 32'(c % 2 == 1));
      chk($sformatf("%s_d_c%0d", tag, c), 32'(if2.mux_d), 32'(c < 8 ? w1 : w2));
      if (c == 1) begin
        @(posedge clk); #1;
        if2.in_valid = 1'b1;
      end else if (c == 3) begin
        @(posedge clk); #1;
        if2.in_data = w2;
      end else if (c == 7) begin
        @(posedge clk);
        push_word(2, 1'b0, w2);
        #1;
        if2.in_valid = 1'b0;
      end
    end
    @(negedge clk);
    chk_idle(if2, {tag, "_end"}, w2, 2'b00);
  endtask

  initial begin
    if1.in_valid = 1'b0; if1.in_data = 4'h0;
    if3.in_valid = 1'b0; if3.in_data = 4'h0;
    if2.in_valid = 1'b0; if2.in_data = 4'h0;
    if4.in_valid = 1'b0; if4.in_data = 4'h0;

    repeat (3) @(negedge clk);
    chk_idle(if1, "rst_in1", 4'h0, 2'b00);
    chk_idle(if3, "rst_in3", 4'h0, 2'b11);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk_idle(if1, "rst_out1", 4'h0, 2'b00);
    chk_idle(if3, "rst_out3", 4'h0, 2'b11);
    chk_idle(if2, "rst_out2", 4'h0, 2'b00);

    run_word(if1, 0, 1, 1'b0, 4'b1011);
    run_word(if3, 1, 3, 1'b1, 4'b0110);
    two_words("b2b", 4'hA, 1'b1, 4'h5, 4'h5);
    two_words("bp", 4'h3, 1'b0, 4'hC, 4'h9);

    start_word(if4, 3, 1'b0, 4'h6, 1'b0, 4'h0);
    repeat (10) @(negedge clk);
    chk("abort_pre_busy", 32'(if4.busy), 32'd1);
    chk("abort_pre_sel", 32'(if4.mux_s), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk_idle(if4, "abort", 4'h0, 2'b00);
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk_idle(if4, "abort_rel", 4'h0, 2'b00);
    run_word(if4, 3, 4, 1'b0, 4'hF);

    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++)
      chk($sformatf("sb_left%0d", k), 32'(exp_q[k].size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
